// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared constants, index types and helpers for the 4x4 keypad matrix scanner.
// Key numbering is row*N_COLS + col throughout.
package keypad_pkg;

    localparam int unsigned N_ROWS = 4;
    localparam int unsigned N_COLS = 4;
    localparam int unsigned N_KEYS = N_ROWS * N_COLS;

    localparam int unsigned ROW_W = $clog2(N_ROWS);
    localparam int unsigned COL_W = $clog2(N_COLS);
    localparam int unsigned KEY_W = $clog2(N_KEYS);

    typedef logic [ROW_W-1:0]  row_idx_t;
    typedef logic [COL_W-1:0]  col_idx_t;
    typedef logic [KEY_W-1:0]  key_idx_t;
    typedef logic [N_KEYS-1:0] key_vec_t;

    typedef struct packed {
        logic     found;
        key_idx_t idx;
    } key_enc_t;

    function automatic key_idx_t key_index(input row_idx_t row, input col_idx_t col);
        return key_idx_t'(row * N_COLS + col);
    endfunction

    // Lowest set bit wins; found=0 and idx=0 for an empty vector.
    function automatic key_enc_t lowest_set(input key_vec_t v);
        key_enc_t r;
        r = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (v[i] && !r.found) begin
                r.found = 1'b1;
                r.idx   = key_idx_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Key event bus from the scanner: debounced map, any-key flag and the press event.
interface keypad_matrix_scanner_if;
    import keypad_pkg::*;

    key_vec_t Key_Map;
    logic     Any_Key;
    logic     Key_Valid;
    key_idx_t Key_Code;

    modport master (
        output Key_Map,
        output Any_Key,
        output Key_Valid,
        output Key_Code
    );

    modport slave (
        input Key_Map,
        input Any_Key,
        input Key_Valid,
        input Key_Code
    );

endinterface

// File: rtl/keypad_matrix_scanner_frame_debouncer.sv
// Whole-frame debouncer: promotes a frame to the key map after DEBOUNCE_FRAMES
// identical frames and reports each new press once, lowest index first.
module frame_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic     CLK,
    input  logic     RESET,
    input  logic     frame_valid,
    input  key_vec_t frame,
    output key_vec_t key_map,
    output logic     key_valid,
    output key_idx_t key_code
);

    localparam logic [3:0] MATCH_LAST = 4'(DEBOUNCE_FRAMES - 1);

    key_vec_t   prev_frame;
    key_vec_t   pending;
    key_vec_t   pending_next;
    key_vec_t   issue_mask;
    logic [3:0] match_cnt;
    logic [3:0] match_next;
    key_idx_t   code_hold;
    key_enc_t   enc;
    logic       map_update;

    always_comb begin
        match_next = match_cnt;
        if (frame == prev_frame) begin
            if (match_cnt != MATCH_LAST) begin
                match_next = match_cnt + 4'd1;
            end
        end else begin
            match_next = '0;
        end
    end

    assign map_update = frame_valid && (match_next == MATCH_LAST);

    // Issue and map update may coincide: the issued bit is never a new press,
    // so clearing it first and then merging new presses is order-independent.
    always_comb begin
        enc          = lowest_set(pending);
        issue_mask   = '0;
        if (enc.found) begin
            issue_mask[enc.idx] = 1'b1;
        end
        pending_next = pending & ~issue_mask;
        if (map_update) begin
            pending_next = (pending_next | (frame & ~key_map)) & frame;
        end
    end

    assign key_valid = enc.found;
    assign key_code  = enc.found ? enc.idx : code_hold;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_frame <= '0;
            match_cnt  <= '0;
            key_map    <= '0;
            pending    <= '0;
            code_hold  <= '0;
        end else begin
            pending <= pending_next;
            if (enc.found) begin
                code_hold <= enc.idx;
            end
            if (frame_valid) begin
                prev_frame <= frame;
                match_cnt  <= match_next;
            end
            if (map_update) begin
                key_map <= frame;
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: strobes one column low per tick, samples the
// synchronized active-low rows into a frame and hands full frames to the debouncer.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 22500,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [N_ROWS-1:0]       Row_In,
    output logic [N_COLS-1:0]       Col_Drive,
    keypad_matrix_scanner_if.master key_bus
);

    localparam int unsigned       TICK_W    = (SCAN_DIV >= 1) ? $clog2(SCAN_DIV + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV);
    localparam col_idx_t          COL_LAST  = col_idx_t'(N_COLS - 1);
    localparam logic [N_COLS-1:0] COL_ONE   = {{(N_COLS-1){1'b0}}, 1'b1};

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    col_idx_t          col_idx;
    col_idx_t          col_next;
    logic [N_ROWS-1:0] row_meta;
    logic [N_ROWS-1:0] row_sync;
    key_vec_t          frame_buf;
    key_vec_t          frame_next;
    logic              frame_valid;
    key_vec_t          key_map;
    logic              key_valid;
    key_idx_t          key_code;
    logic              any_key;

    // Rows are asynchronous; reset them to the released level.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= Row_In;
            row_sync <= row_meta;
        end
    end

    assign tick        = (tick_cnt == TICK_LAST);
    assign col_next    = col_idx + 1'b1;
    assign frame_valid = tick && (col_idx == COL_LAST);

    always_comb begin
        frame_next = frame_buf;
        for (int unsigned r = 0; r < N_ROWS; r++) begin
            frame_next[key_index(row_idx_t'(r), col_idx)] = ~row_sync[r];
        end
    end

    // Col_Drive moves on the sampling edge so the new column settles a full period.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_cnt  <= '0;
            col_idx   <= '0;
            Col_Drive <= ~COL_ONE;
            frame_buf <= '0;
            any_key   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            any_key  <= |key_map;
            if (tick) begin
                frame_buf <= frame_next;
                col_idx   <= col_next;
                Col_Drive <= ~(COL_ONE << col_next);
            end
        end
    end

    frame_debouncer #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debouncer (
        .CLK         (CLK),
        .RESET       (RESET),
        .frame_valid (frame_valid),
        .frame       (frame_next),
        .key_map     (key_map),
        .key_valid   (key_valid),
        .key_code    (key_code)
    );

    assign key_bus.Key_Map   = key_map;
    assign key_bus.Any_Key   = any_key;
    assign key_bus.Key_Valid = key_valid;
    assign key_bus.Key_Code  = key_code;

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Reads a 4x4 passive key matrix and emits debounced key events.
- Drives one column low at a time, samples the four active-low row inputs, and assembles a 16-bit frame per full scan.
- Debounces whole frames and reports each new key press as a one-cycle code+valid event.
- Input-side counterpart to the dot-matrix LED driver: same column-multiplexed scan scheme, same tick timing style.

Parameters:
- SCAN_DIV, 22500: column period is SCAN_DIV+1 clock cycles (tick when the counter equals SCAN_DIV).
- DEBOUNCE_FRAMES, 3: number of consecutive identical frames required to update the stable key map; legal range 2..15.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous active-high reset.
- Row_In  input  4  matrix rows, active-low (board pull-ups); asynchronous to CLK.
- Col_Drive  output  4  column strobes, active-low one-hot.
- Key_Map  output  16  debounced pressed map; bit index = row*4 + col; 1 = pressed.
- Any_Key  output  1  OR of Key_Map.
- Key_Valid  output  1  one-cycle pulse announcing a new press.
- Key_Code  output  4  index of the reported key; holds its value until the next Key_Valid.

Behaviour:
- Reset (synchronous, on CLK when RESET=1) sets:
  - tick counter 0; column index 0; Col_Drive 4'b1110
  - frame buffer, previous frame, match counter, Key_Map, pending mask all 0
  - Any_Key 0; Key_Valid 0; Key_Code 0.
- Reset mid-scan discards the partial frame and the debounce history; the first post-reset tick samples column 0.
- Row_In passes through a 2-FF synchronizer. Samples use the synchronized value, inverted so that 1 = pressed.
- Tick counter runs 0..SCAN_DIV and wraps to 0. A tick is the cycle where counter == SCAN_DIV.
- On tick:
  - Synchronized rows are written into frame bits {r*4+col} for the current column.
  - Column index advances (3 wraps to 0).
  - Col_Drive updates on the same edge, giving each column a full settle period before it is sampled.
- Frame complete = tick with column index 3. The comparison uses the frame including the column-3 bits just written (next-state value).
- Debounce at frame complete:
  - If new frame == previous frame, the match counter increments, saturating at DEBOUNCE_FRAMES-1; otherwise it resets to 0.
  - Previous frame <= new frame.
  - When the counter reaches DEBOUNCE_FRAMES-1, Key_Map <= new frame. Key_Map therefore changes DEBOUNCE_FRAMES frames after the input settles.
- Pending mask:
  - On each Key_Map update, pending <= (pending | (new_map & ~old_map)) & new_map.
  - A released key clears its pending bit; a key released before it is reported is never reported.
- Event issue:
  - In any cycle with pending != 0, Key_Valid=1 and Key_Code = lowest set index; that bit clears the same cycle.
  - Key_Valid is otherwise 0. Simultaneous new presses are reported one per cycle, in ascending index order.
  - If a pending update and an issue fall in the same cycle, both take effect: issued bit cleared, new bits ORed.
- Release produces no event. Holding a key produces no repeat.
- Any_Key is registered from Key_Map and lags it by one cycle.
- Ghosting (3+ keys on a rectangle) is not detected; frame bits are reported as sampled.
- Widths:
  - Tick counter: 15 bits at the default. Use $clog2(SCAN_DIV+1), minimum 1.
  - Match counter: 4 bits.

Decomposition:
- Package keypad_pkg:
  - constants N_ROWS=4, N_COLS=4, N_KEYS=16
  - function key_index(row,col)
  - lowest-set-bit priority encoder function (16 -> 4 + found flag).
- One sub-module: frame_debouncer, holding previous frame, match counter, Key_Map and pending logic. It is driven by frame_valid and frame[15:0].
- Scan counter, column drive and synchronizer stay in the top.

Test Plan (SCAN_DIV=3, DEBOUNCE_FRAMES=2; 4 cycles/column, 16 cycles/frame):
- Reset check: assert RESET for 3 cycles with Row_In=4'hF -> Col_Drive=4'b1110, Key_Map=0, Key_Valid=0; the sequence 1110,1101,1011,0111 repeats with each step lasting 4 cycles.
- Single press: model key (row 2, col 1) as Row_In[2]=0 whenever Col_Drive[1]=0 -> Key_Map=16'h0200 after 2 complete frames; exactly one Key_Valid with Key_Code=9; no further pulses while held.
- Bounce: toggle key 9 every 5 cycles for 3 frames, then hold -> no Key_Valid during bouncing; a single Key_Code=9 event 2 frames after the hold begins.
- Simultaneous press: keys 0, 5 and 15 pressed together -> Key_Map=16'h8021; Key_Valid on 3 consecutive cycles with codes 0, 5, 15.
- Release/re-press: release key 9 -> Key_Map bit clears 2 frames later with no pulse; re-press -> new Key_Code=9 event.
- Mid-scan reset: assert RESET during column 2 of a frame while key 3 is pressed -> all outputs back to reset values; after release of RESET, Key_Map=16'h0008 only after 2 fresh full frames.
